// File: rtl/ext_platform_sim_wrapper.sv
// Simulation model of the PS clock/reset front end: PL reset sequencing,
// emulated clock-wizard lock, divided clk_out1 and staged interconnect/peripheral resets.
//
// state        | meaning
// -------------|-----------------------------------------------------------
// RESET        | pl_rst asserted, every output forced low
// HOLD         | pl_resetn1 held low for RESET_HOLD_CYCLES edges
// WAIT_LOCK    | pl_resetn1 high, waiting LOCK_CYCLES for emulated MMCM lock
// STAGE_IC     | locked, interconnect reset released after PERIPH_DELAY
// STAGE_PERIPH | interconnect out of reset, peripheral released after PERIPH_DELAY
// RUN          | sequence complete, outputs held until a reset request
module ext_platform_sim_wrapper #(
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int LOCK_CYCLES       = 32,
  parameter int PERIPH_DELAY      = 4,
  parameter int CLK_OUT1_DIV      = 2,
  parameter int CNT_W             = 32
) (
  input  logic             pl_clk0,
  input  logic             pl_rst,
  input  logic             soft_rst_req,
  output logic             pl_resetn1,
  output logic             clk_wiz_locked,
  output logic             clk_out1,
  output logic             clk_out1_rise,
  output logic             interconnect_aresetn,
  output logic             peripheral_aresetn,
  output logic [CNT_W-1:0] pl_clk0_cnt,
  output logic [3:0]       post_reset_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_RESET        = 3'd0,
    ST_HOLD         = 3'd1,
    ST_WAIT_LOCK    = 3'd2,
    ST_STAGE_IC     = 3'd3,
    ST_STAGE_PERIPH = 3'd4,
    ST_RUN          = 3'd5
  } seq_state_t;

  // The edge that enters HOLD is itself the first hold edge, hence the -1.
  localparam logic [31:0] HOLD_LOAD  = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES);
  localparam logic [31:0] STAGE_LOAD = 32'(PERIPH_DELAY);
  localparam logic [31:0] DIV_LAST   = 32'(CLK_OUT1_DIV - 1);
  localparam logic [3:0]  POST_MAX   = 4'd10;

  seq_state_t  state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic        resetn_q, resetn_d;
  logic        locked_q, locked_d;
  logic        ic_q, ic_d;
  logic        per_q, per_d;
  logic        seq_clear;
  logic        tmr_done;

  logic [31:0]      div_q;
  logic             clk_out1_q;
  logic             rise_q;
  logic [CNT_W-1:0] cyc_q;
  logic [3:0]       post_q;

  always_ff @(posedge pl_clk0) begin
    state_q  <= state_d;
    tmr_q    <= tmr_d;
    resetn_q <= resetn_d;
    locked_q <= locked_d;
    ic_q     <= ic_d;
    per_q    <= per_d;
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    resetn_d  = resetn_q;
    locked_d  = locked_q;
    ic_d      = ic_q;
    per_d     = per_q;
    seq_clear = 1'b0;
    tmr_done  = (tmr_q <= 32'd1);

    case (state_q)
      ST_RESET: begin
        state_d = ST_HOLD;
        tmr_d   = HOLD_LOAD;
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_WAIT_LOCK;
          tmr_d    = LOCK_LOAD;
          resetn_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (tmr_done) begin
          state_d  = ST_STAGE_IC;
          tmr_d    = STAGE_LOAD;
          locked_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      ST_STAGE_IC: begin
        if (tmr_done) begin
          state_d = ST_STAGE_PERIPH;
          tmr_d   = STAGE_LOAD;
          ic_d    = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      ST_STAGE_PERIPH: begin
        if (tmr_done) begin
          state_d = ST_RUN;
          tmr_d   = '0;
          per_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RESET;
        tmr_d   = '0;
      end
    endcase

    // Soft request is ignored until the hold phase has finished.
    if (soft_rst_req && (state_q inside {ST_WAIT_LOCK, ST_STAGE_IC, ST_STAGE_PERIPH, ST_RUN})) begin
      state_d   = ST_HOLD;
      tmr_d     = HOLD_LOAD;
      resetn_d  = 1'b0;
      locked_d  = 1'b0;
      ic_d      = 1'b0;
      per_d     = 1'b0;
      seq_clear = 1'b1;
    end

    if (pl_rst) begin
      state_d   = ST_RESET;
      tmr_d     = '0;
      resetn_d  = 1'b0;
      locked_d  = 1'b0;
      ic_d      = 1'b0;
      per_d     = 1'b0;
      seq_clear = 1'b1;
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (pl_rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (seq_clear || !resetn_q) begin
      post_q <= '0;
    end else if (post_q < POST_MAX) begin
      post_q <= post_q + 4'd1;
    end
  end

  // Divider restarts from zero on the edge that reports lock.
  always_ff @(posedge pl_clk0) begin
    if (seq_clear || !locked_q) begin
      div_q      <= '0;
      clk_out1_q <= 1'b0;
      rise_q     <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      clk_out1_q <= ~clk_out1_q;
      rise_q     <= ~clk_out1_q;
    end else begin
      div_q  <= div_q + 32'd1;
      rise_q <= 1'b0;
    end
  end

  assign pl_resetn1           = resetn_q;
  assign clk_wiz_locked       = locked_q;
  assign interconnect_aresetn = ic_q;
  assign peripheral_aresetn   = per_q;
  assign clk_out1             = clk_out1_q;
  assign clk_out1_rise        = rise_q;
  assign pl_clk0_cnt          = cyc_q;
  assign post_reset_cnt       = post_q;
  assign state                = state_q;

endmodule

// File: tb/tb_ext_platform_sim_wrapper.sv
// Bench for ext_platform_sim_wrapper: directed reset/soft-reset scenarios then random
// pl_rst/soft_rst_req traffic, checked against a timeline model of the sequence.
module tb_ext_platform_sim_wrapper;
  localparam int H = 16;
  localparam int L = 32;
  localparam int P = 4;
  localparam int D = 2;

  logic pl_clk0 = 1'b0;
  logic pl_rst = 1'b1;
  logic soft_rst_req = 1'b0;

  logic        a_rn1, a_lk, a_co, a_cr, a_ic, a_pe;
  logic [31:0] a_cnt;
  logic [3:0]  a_post;
  logic [2:0]  a_st;

  logic        b_rn1, b_lk, b_co, b_cr, b_ic, b_pe;
  logic [3:0]  b_cnt;
  logic [3:0]  b_post;
  logic [2:0]  b_st;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;
  int base = 0;
  bit in_rst = 1'b1;

  ext_platform_sim_wrapper #(
    .RESET_HOLD_CYCLES(H), .LOCK_CYCLES(L), .PERIPH_DELAY(P), .CLK_OUT1_DIV(D), .CNT_W(32)
  ) u_dut (
    .pl_clk0(pl_clk0), .pl_rst(pl_rst), .soft_rst_req(soft_rst_req),
    .pl_resetn1(a_rn1), .clk_wiz_locked(a_lk), .clk_out1(a_co), .clk_out1_rise(a_cr),
    .interconnect_aresetn(a_ic), .peripheral_aresetn(a_pe), .pl_clk0_cnt(a_cnt),
    .post_reset_cnt(a_post), .state(a_st)
  );

  ext_platform_sim_wrapper #(
    .RESET_HOLD_CYCLES(H), .LOCK_CYCLES(L), .PERIPH_DELAY(P), .CLK_OUT1_DIV(D), .CNT_W(4)
  ) u_dut_w4 (
    .pl_clk0(pl_clk0), .pl_rst(pl_rst), .soft_rst_req(soft_rst_req),
    .pl_resetn1(b_rn1), .clk_wiz_locked(b_lk), .clk_out1(b_co), .clk_out1_rise(b_cr),
    .interconnect_aresetn(b_ic), .peripheral_aresetn(b_pe), .pl_clk0_cnt(b_cnt),
    .post_reset_cnt(b_post), .state(b_st)
  );

  always #5 pl_clk0 = ~pl_clk0;

  // Phase of the sequence k edges after the edge that entered HOLD.
  function automatic int exp_state(int k);
    if (k < H - 1) return 1;
    if (k < H - 1 + L) return 2;
    if (k < H - 1 + L + P) return 3;
    if (k < H - 1 + L + 2 * P) return 4;
    return 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp_v, n_edge);
    end
  endtask

  task automatic check_all();
    int k, m, st, post;
    logic rn1, lk, ic, pe, co, cr;
    if (in_rst) begin
      st = 0; post = 0;
      rn1 = 0; lk = 0; ic = 0; pe = 0; co = 0; cr = 0;
    end else begin
      k    = n_edge - base;
      st   = exp_state(k);
      rn1  = (k >= H - 1);
      lk   = (k >= H - 1 + L);
      ic   = (k >= H - 1 + L + P);
      pe   = (k >= H - 1 + L + 2 * P);
      post = (k - (H - 1) > 10) ? 10 : ((k - (H - 1) < 0) ? 0 : k - (H - 1));
      m    = k - (H - 1 + L);
      co   = (m >= 0) && (((m / D) % 2) == 1);
      cr   = (m > 0) && ((m % (2 * D)) == D);
    end
    chk("state",      {29'd0, a_st}, st);
    chk("pl_resetn1", {31'd0, a_rn1}, {31'd0, rn1});
    chk("locked",     {31'd0, a_lk}, {31'd0, lk});
    chk("ic_aresetn", {31'd0, a_ic}, {31'd0, ic});
    chk("pe_aresetn", {31'd0, a_pe}, {31'd0, pe});
    chk("post_cnt",   {28'd0, a_post}, post);
    chk("clk_out1",   {31'd0, a_co}, {31'd0, co});
    chk("clk_rise",   {31'd0, a_cr}, {31'd0, cr});
    chk("cnt",        a_cnt, n_edge);
    chk("w4_cnt",     {28'd0, b_cnt}, n_edge % 16);
    chk("w4_state",   {29'd0, b_st}, st);
    chk("w4_outs",    {26'd0, b_rn1, b_lk, b_ic, b_pe, b_co, b_cr},
                      {26'd0, rn1, lk, ic, pe, co, cr});
    chk("w4_post",    {28'd0, b_post}, post);
  endtask

  task automatic step();
    int pre;
    @(posedge pl_clk0);
    if (pl_rst) begin
      in_rst = 1'b1;
      n_edge = 0;
    end else if (in_rst) begin
      in_rst = 1'b0;
      n_edge = 1;
      base   = 1;
    end else begin
      pre = exp_state(n_edge - base);
      n_edge++;
      if (soft_rst_req && pre >= 2) base = n_edge;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Power-on reset for 5 cycles.
    pl_rst = 1'b1;
    repeat (5) step();

    // Default sequence through RUN and the clk_out1 pattern.
    pl_rst = 1'b0;
    repeat (60) step();
    chk("run_at_60", {29'd0, a_st}, 32'd5);

    // Soft reset sampled on edge 71.
    while (n_edge < 70) step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    chk("soft_low_71", {28'd0, a_rn1, a_lk, a_ic, a_pe}, 32'd0);
    while (n_edge < 86) step();
    chk("soft_rn1_86", {31'd0, a_rn1}, 32'd1);
    repeat (10) step();

    // Soft request held through HOLD is ignored.
    pl_rst = 1'b1;
    repeat (2) step();
    pl_rst = 1'b0;
    soft_rst_req = 1'b1;
    repeat (16) step();
    soft_rst_req = 1'b0;
    chk("held_rn1_16", {31'd0, a_rn1}, 32'd1);
    while (n_edge < 49) step();

    // pl_rst mid-sequence on edge 50.
    pl_rst = 1'b1;
    step();
    chk("mid_rst_cnt", a_cnt, 32'd0);
    pl_rst = 1'b0;

    // Random traffic; the 4-bit instance wraps many times along the way.
    for (int i = 0; i < 1500; i++) begin
      pl_rst       = ($urandom_range(0, 299) == 0);
      soft_rst_req = ($urandom_range(0, 59) == 0) || (soft_rst_req && $urandom_range(0, 2) == 0);
      step();
    end
    pl_rst = 1'b0;
    soft_rst_req = 1'b0;
    repeat (80) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
